operar_vetores_acc: RTL and testbench
=====================================

# operar_vetores_acc

Parametrised, registered successor to the combinational vector operator. Applies a selectable bitwise operation (OR/AND/XOR) to two WIDTH-bit operands and produces the same outputs as the combinational block: bitwise result, logical OR, and inverted concatenation. It adds a valid/ready stream interface, a one-entry output register, and an optional accumulate mode that folds DEPTH consecutive beats into one result. It sits between an operand producer and a result consumer in the vector-processing datapath.

## Interface
- WIDTH, 3, operand width (≥1)
- DEPTH, 4, beats per accumulation group (≥2)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  2  00 OR, 01 AND, 10 XOR, 11 reserved (behaves as OR)
- acumular  in  1  1 = accumulate DEPTH beats, 0 = single beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- saida_bit_a_bit  out  WIDTH  bitwise/accumulated result
- saida_or_logico  out  1  |saida_bit_a_bit
- saida_not  out  2*WIDTH  ~{a,b} of the last accepted beat
- contagem  out  $clog2(DEPTH)  beats accepted in the current group

## Operation
- Beat accepted when in_valid && in_ready; result accepted when out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational; same-cycle drain-and-refill allowed).
- States: OCIOSO (no group open), ACUMULANDO (group open), with out_valid tracked by a separate flag.
- OCIOSO, beat accepted: op and acumular latched for the whole beat/group.
  - acumular=0: result = op(a,b) registered; out_valid set; stay OCIOSO.
  - acumular=1: acc = op(a,b); contagem=1; go ACUMULANDO.
- ACUMULANDO, beat accepted: op and acumular inputs ignored; acc = latched_op(acc, latched_op(a,b)); contagem+1. On DEPTH-th beat: result = acc update, out_valid set, contagem=0, go OCIOSO.
- saida_not always reflects ~{a,b} of the most recently accepted beat; saida_or_logico derived from the registered result.
- Outputs hold stable while out_valid && !out_ready.
- out_valid cleared on acceptance unless a new result is loaded the same cycle (new result wins).

## Timing
- Reset: out_valid=0, saida_bit_a_bit=0, saida_or_logico=0, saida_not=0, contagem=0, state OCIOSO, in_ready=1.
- Single mode latency: beat accepted at edge k → out_valid high after edge k.
- Accumulate: out_valid high after the edge accepting the DEPTH-th beat; no out_valid during the group.
- Throughput: one beat/cycle when out_ready held high.
- Reset mid-group: group discarded, contagem=0, pending result dropped.
- in_valid low in ACUMULANDO: group stays open indefinitely, acc held.

## Configuration
- OPERAR_VETORES_ACUM_EN defined: accumulate mode, ACUMULANDO state, acc register and contagem present as above.
- Not defined: acumular ignored, every beat single mode, contagem tied to 0, no accumulator logic.

## Structure
- Package operar_vetores_pkg: op encodings (OP_OR, OP_AND, OP_XOR), state enum (OCIOSO, ACUMULANDO).
- Sub-module operar_vetores_alu: combinational WIDTH-bit op(x,y,op), instantiated for both operand and fold paths.

## Test plan
(WIDTH=3, DEPTH=4)
- Reset asserted → all outputs 0, in_ready=1; deassert, no stimulus → outputs unchanged.
- Single OR a=011 b=010 → next cycle out_valid=1, saida_bit_a_bit=011, saida_or_logico=1, saida_not=100101.
- Single OR a=000 b=000 → saida_bit_a_bit=000, saida_or_logico=0, saida_not=111111.
- Accumulate XOR, beats (001,000),(010,000),(100,000),(111,000); op changed to AND after beat 1 → out_valid only after beat 4, saida_bit_a_bit=000, saida_or_logico=0, saida_not=000111, contagem 1,2,3,0.
- Backpressure: result pending, out_ready=0, in_valid=1 → in_ready=0, outputs stable; raise out_ready with single AND a=101 b=011 → same cycle accept, next result 001.
- Reset mid-group after 2 accumulate beats → contagem=0; next 4-beat OR group of (001,000)×4 → 001, unaffected by discarded beats.

Source files
------------

// File: rtl/operar_vetores_pkg.sv
// -----------------------------------------------------------------------------
// operar_vetores_pkg
// Shared definitions for the registered vector operator:
//   op_t    : operation encodings (value 2'b11 is reserved and treated as OR)
//   state_t : group-tracking state (OCIOSO = no group open, ACUMULANDO = open)
// -----------------------------------------------------------------------------
package operar_vetores_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_OR  = 2'b00,
      OP_AND = 2'b01,
      OP_XOR = 2'b10
   } op_t;

   typedef enum logic {
      OCIOSO     = 1'b0,
      ACUMULANDO = 1'b1
   } state_t;

endpackage : operar_vetores_pkg

// File: rtl/operar_vetores_acc_if.sv
// -----------------------------------------------------------------------------
// operar_vetores_acc_if
// Operand/result stream bundle for operar_vetores_acc.
//   master : operand producer + result consumer side (drives in_valid, a, b,
//            op, acumular, out_ready)
//   slave  : the operator block (drives in_ready, out_valid and result outputs)
// -----------------------------------------------------------------------------
interface operar_vetores_acc_if #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
);
   localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [1:0]           op;
   logic                 acumular;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     saida_bit_a_bit;
   logic                 saida_or_logico;
   logic [2*WIDTH-1:0]   saida_not;
   logic [CNT_W-1:0]     contagem;

   modport master (
      output in_valid, a, b, op, acumular, out_ready,
      input  in_ready, out_valid, saida_bit_a_bit, saida_or_logico,
             saida_not, contagem
   );

   modport slave (
      input  in_valid, a, b, op, acumular, out_ready,
      output in_ready, out_valid, saida_bit_a_bit, saida_or_logico,
             saida_not, contagem
   );

endinterface : operar_vetores_acc_if

// File: rtl/operar_vetores_alu.sv
// -----------------------------------------------------------------------------
// operar_vetores_alu
// Combinational WIDTH-bit bitwise operator z = op(x, y).
//   x_i, y_i : operands
//   op_i     : OP_OR / OP_AND / OP_XOR; the reserved code falls back to OR
//   z_o      : result
// -----------------------------------------------------------------------------
module operar_vetores_alu
   import operar_vetores_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic [1:0]       op_i,
   output logic [WIDTH-1:0] z_o
);

   always_comb begin
      z_o = x_i | y_i;
      case (op_i)
         OP_AND:  z_o = x_i & y_i;
         OP_XOR:  z_o = x_i ^ y_i;
         default: z_o = x_i | y_i;
      endcase
   end

endmodule : operar_vetores_alu

// File: rtl/operar_vetores_acc.sv
// -----------------------------------------------------------------------------
// operar_vetores_acc
// Registered vector operator with valid/ready streaming and a one-entry
// output register. Optional accumulate mode (macro OPERAR_VETORES_ACUM_EN)
// folds DEPTH consecutive beats into one result.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : operar_vetores_acc_if.slave
//           in_valid/in_ready, a, b, op, acumular  -> operand beat
//           out_valid/out_ready, saida_bit_a_bit, saida_or_logico,
//           saida_not, contagem                     -> result side
// Without OPERAR_VETORES_ACUM_EN every beat is single mode, acumular is
// ignored and contagem is tied to zero.
// -----------------------------------------------------------------------------
module operar_vetores_acc
   import operar_vetores_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   operar_vetores_acc_if.slave  bus
);

   localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     res_q, res_d;
   logic [2*WIDTH-1:0]   not_q, not_d;

   logic                 beat_fire;
   logic [1:0]           beat_op;
   logic [WIDTH-1:0]     beat_res;

   // Drain-and-refill in the same cycle is allowed, so ready looks through
   // to the consumer.
   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign beat_fire    = bus.in_valid && bus.in_ready;

   operar_vetores_alu #(.WIDTH(WIDTH)) u_alu_beat (
      .x_i  (bus.a),
      .y_i  (bus.b),
      .op_i (beat_op),
      .z_o  (beat_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         res_q       <= '0;
         not_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         not_q       <= not_d;
      end
   end

`ifdef OPERAR_VETORES_ACUM_EN
   state_t               state_q, state_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [1:0]           op_q, op_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     fold_res;

   // Inside a group the operation latched on the first beat applies to both
   // the operand pair and the fold; the live op input is ignored.
   assign beat_op = (state_q == ACUMULANDO) ? op_q : bus.op;

   operar_vetores_alu #(.WIDTH(WIDTH)) u_alu_fold (
      .x_i  (acc_q),
      .y_i  (beat_res),
      .op_i (op_q),
      .z_o  (fold_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OCIOSO;
         acc_q   <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      res_d       = res_q;
      not_d       = not_q;
      // A result taken this cycle clears valid unless a new one loads below.
      out_valid_d = out_valid_q && !bus.out_ready;

      if (beat_fire) begin
         not_d = ~{bus.a, bus.b};
         case (state_q)
            OCIOSO: begin
               if (bus.acumular) begin
                  acc_d   = beat_res;
                  op_d    = bus.op;
                  cnt_d   = CNT_W'(1);
                  state_d = ACUMULANDO;
               end else begin
                  res_d       = beat_res;
                  out_valid_d = 1'b1;
               end
            end
            ACUMULANDO: begin
               acc_d = fold_res;
               if (cnt_q == CNT_W'(DEPTH - 1)) begin
                  res_d       = fold_res;
                  out_valid_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = OCIOSO;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = OCIOSO;
         endcase
      end
   end

   assign bus.contagem = cnt_q;
`else
   logic unused_acumular;

   assign beat_op         = bus.op;
   assign unused_acumular = bus.acumular;

   always_comb begin
      res_d       = res_q;
      not_d       = not_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      if (beat_fire) begin
         not_d       = ~{bus.a, bus.b};
         res_d       = beat_res;
         out_valid_d = 1'b1;
      end
   end

   assign bus.contagem = '0;
`endif

   assign bus.out_valid       = out_valid_q;
   assign bus.saida_bit_a_bit = res_q;
   assign bus.saida_or_logico = |res_q;
   assign bus.saida_not       = not_q;

endmodule : operar_vetores_acc

// File: tb/tb_operar_vetores_acc.sv
// -----------------------------------------------------------------------------
// tb_operar_vetores_acc
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level model (queue of beats in the open group, folded with
// plain arithmetic when the group completes).
// -----------------------------------------------------------------------------
module tb_operar_vetores_acc;

   localparam int W = 3;
   localparam int D = 4;
   localparam int CW = $clog2(D);
`ifdef OPERAR_VETORES_ACUM_EN
   localparam bit ACC_EN = 1'b1;
`else
   localparam bit ACC_EN = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   operar_vetores_acc_if #(.WIDTH(W), .DEPTH(D)) bus ();

   operar_vetores_acc #(.WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic             m_valid;
   logic [W-1:0]     m_res;
   logic [2*W-1:0]   m_not;
   logic [1:0]       m_gop;
   beat_t            m_grp[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] f_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      if (o == 2'd1)      return x & y;
      else if (o == 2'd2) return x ^ y;
      else                return x | y;
   endfunction

   function automatic logic [W-1:0] fold_group(input logic [1:0] o);
      logic [W-1:0] acc;
      acc = f_op(o, m_grp[0].a, m_grp[0].b);
      for (int i = 1; i < m_grp.size(); i++)
         acc = f_op(o, acc, f_op(o, m_grp[i].a, m_grp[i].b));
      return acc;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_res   = '0;
      m_not   = '0;
      m_gop   = '0;
      m_grp.delete();
   endtask

   task automatic check_outputs(input string pfx);
      check_val({pfx, "_out_valid"}, 32'(bus.out_valid), 32'(m_valid));
      check_val({pfx, "_bit_a_bit"}, 32'(bus.saida_bit_a_bit), 32'(m_res));
      check_val({pfx, "_or_logico"}, 32'(bus.saida_or_logico), 32'(|m_res));
      check_val({pfx, "_not"}, 32'(bus.saida_not), 32'(m_not));
      check_val({pfx, "_contagem"}, 32'(bus.contagem), 32'(m_grp.size()));
   endtask

   // One clock cycle: drive at negedge, check ready, update model at posedge.
   task automatic step(input bit v, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic [1:0] opi, input bit acc, input bit ordy);
      bit exp_ready, fire, load;
      beat_t bt;
      @(negedge clk);
      bus.in_valid  = v;
      bus.a         = ai;
      bus.b         = bi;
      bus.op        = opi;
      bus.acumular  = acc;
      bus.out_ready = ordy;
      #1;
      exp_ready = !m_valid || ordy;
      check_val("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      fire = v && exp_ready;
      @(posedge clk);
      load = 1'b0;
      if (m_valid && ordy)
         $display("result taken: %b", m_res);
      if (fire) begin
         bt.a = ai;
         bt.b = bi;
         m_not = ~{ai, bi};
         if (m_grp.size() == 0) begin
            if (ACC_EN && acc) begin
               m_gop = opi;
               m_grp.push_back(bt);
            end else begin
               m_res = f_op(opi, ai, bi);
               load  = 1'b1;
            end
         end else begin
            m_grp.push_back(bt);
            if (m_grp.size() == D) begin
               m_res = fold_group(m_gop);
               load  = 1'b1;
               m_grp.delete();
            end
         end
         $display("beat a=%b b=%b op=%0d acc=%0d group=%0d", ai, bi, opi, acc, m_grp.size());
      end
      m_valid = load ? 1'b1 : (m_valid && !ordy);
      #1;
      check_outputs("cyc");
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("rst");
      check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = '0;
      bus.acumular  = 1'b0;
      bus.out_ready = 1'b0;
      model_reset();
      #3;
      check_outputs("init");
      check_val("init_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // idle after reset: nothing moves
      step(0, '0, '0, 2'd0, 0, 0);
      step(0, '0, '0, 2'd0, 0, 1);

      // single OR
      step(1, 3'b011, 3'b010, 2'd0, 0, 1);
      check_val("t_or_res", 32'(bus.saida_bit_a_bit), 32'(3'b011));
      check_val("t_or_not", 32'(bus.saida_not), 32'(6'b100101));
      check_val("t_or_valid", 32'(bus.out_valid), 32'd1);
      step(1, 3'b000, 3'b000, 2'd0, 0, 1);
      check_val("t_zero_res", 32'(bus.saida_bit_a_bit), 32'(3'b000));
      check_val("t_zero_or", 32'(bus.saida_or_logico), 32'd0);
      check_val("t_zero_not", 32'(bus.saida_not), 32'(6'b111111));

      // accumulate XOR group, op input changes to AND mid-group
      step(1, 3'b001, 3'b000, 2'd2, 1, 1);
      step(1, 3'b010, 3'b000, 2'd1, 1, 1);
      step(1, 3'b100, 3'b000, 2'd1, 1, 1);
      step(1, 3'b111, 3'b000, 2'd1, 1, 1);
`ifdef OPERAR_VETORES_ACUM_EN
      check_val("t_acc_res", 32'(bus.saida_bit_a_bit), 32'(3'b000));
      check_val("t_acc_valid", 32'(bus.out_valid), 32'd1);
      check_val("t_acc_cnt", 32'(bus.contagem), 32'd0);
`endif
      check_val("t_acc_not", 32'(bus.saida_not), 32'(6'b000111));

      // backpressure: pending result blocks input, then drain-and-refill
      step(1, 3'b110, 3'b001, 2'd0, 0, 1);
      step(1, 3'b111, 3'b111, 2'd0, 0, 0);
      check_val("t_bp_hold", 32'(bus.saida_bit_a_bit), 32'(3'b111));
      step(1, 3'b101, 3'b011, 2'd1, 0, 1);
      check_val("t_bp_res", 32'(bus.saida_bit_a_bit), 32'(3'b001));

      // reset mid-group, then a clean OR group
      step(1, 3'b110, 3'b110, 2'd0, 1, 1);
      step(1, 3'b111, 3'b000, 2'd0, 1, 1);
      do_reset();
      for (int i = 0; i < D; i++)
         step(1, 3'b001, 3'b000, 2'd0, 1, 1);
      check_val("t_rst_grp", 32'(bus.saida_bit_a_bit), 32'(3'b001));

      // randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0)
            do_reset();
         else
            step($urandom_range(0, 9) < 7, W'($urandom), W'($urandom),
                 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 7);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_operar_vetores_acc
